// File: rtl/motion_arbiter.sv
// motion_arbiter: top-level drive-path sequencer. Alternates spiral_move and
// turn_around_move, separated by a motors-off settle gap, and muxes the
// active behaviour's speed/command onto the motor bus.
module motion_arbiter #(
    parameter int          SETTLE_CYCLES = 4,
    parameter int          TURN_TIMEOUT  = 1023,
    parameter logic [9:0]  LFSR_SEED     = 10'h2A5,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             bump,
    input  logic             done_spin,
    input  logic [2:0]       spiral_speed,
    input  logic [9:0]       spiral_cmd,
    input  logic [2:0]       turn_speed,
    input  logic [9:0]       turn_cmd,
    output logic             spiral_enable,
    output logic             turn_enable,
    output logic [9:0]       random_angle,
    output logic [2:0]       output_speed,
    output logic [9:0]       motion_command,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] bump_count,
    output logic             timeout_flag
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SPIRAL = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    state_t            pend_state;
    state_t            nxt_pend;
    logic [SET_W-1:0]  settle_cnt;
    logic [SET_W-1:0]  nxt_settle;
    logic [TO_W-1:0]   turn_cnt;
    logic [TO_W-1:0]   nxt_turn;
    logic              accept_bump;
    logic              turn_timeout;
    logic [2:0]        nxt_speed;
    logic [9:0]        nxt_cmd;
    logic [9:0]        lfsr;

    // Enables and state are decoded straight from the state register
    assign state         = cur_state;
    assign spiral_enable = (cur_state == ST_SPIRAL);
    assign turn_enable   = (cur_state == ST_TURN);

    // State register together with the settle and turn-timeout counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= ST_IDLE;
            pend_state <= ST_SPIRAL;
            settle_cnt <= '0;
            turn_cnt   <= '0;
        end else begin
            cur_state  <= nxt_state;
            pend_state <= nxt_pend;
            settle_cnt <= nxt_settle;
            turn_cnt   <= nxt_turn;
        end
    end

    // Next-state logic; stop overrides every other event, and the bus is only
    // loaded while the current mode persists so every gap drives zero
    always_comb begin
        nxt_state    = cur_state;
        nxt_pend     = pend_state;
        nxt_settle   = settle_cnt;
        nxt_turn     = '0;
        accept_bump  = 1'b0;
        turn_timeout = 1'b0;
        nxt_speed    = 3'd0;
        nxt_cmd      = 10'd0;

        case (cur_state)
            ST_IDLE: begin
                if (start) begin
                    nxt_state  = ST_SETTLE;
                    nxt_pend   = ST_SPIRAL;
                    nxt_settle = SET_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    nxt_state = pend_state;
                end else begin
                    nxt_settle = settle_cnt - SET_W'(1);
                end
            end
            ST_SPIRAL: begin
                if (bump) begin
                    accept_bump = 1'b1;
                    nxt_state   = ST_SETTLE;
                    nxt_pend    = ST_TURN;
                    nxt_settle  = SET_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_TURN: begin
                if (done_spin) begin
                    nxt_state  = ST_SETTLE;
                    nxt_pend   = ST_SPIRAL;
                    nxt_settle = SET_W'(SETTLE_CYCLES - 1);
                end else if (turn_cnt == TO_W'(TURN_TIMEOUT - 1)) begin
                    turn_timeout = 1'b1;
                    nxt_state    = ST_SETTLE;
                    nxt_pend     = ST_SPIRAL;
                    nxt_settle   = SET_W'(SETTLE_CYCLES - 1);
                end else begin
                    nxt_turn = turn_cnt + TO_W'(1);
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        if (stop) begin
            nxt_state    = ST_IDLE;
            accept_bump  = 1'b0;
            turn_timeout = 1'b0;
        end

        if (nxt_state == cur_state) begin
            if (cur_state == ST_SPIRAL) begin
                nxt_speed = spiral_speed;
                nxt_cmd   = spiral_cmd;
            end else if (cur_state == ST_TURN) begin
                nxt_speed = turn_speed;
                nxt_cmd   = turn_cmd;
            end
        end
    end

    // Free-running LFSR, angle capture, bump counter, timeout flag and motor bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr           <= LFSR_SEED;
            random_angle   <= '0;
            bump_count     <= '0;
            timeout_flag   <= 1'b0;
            output_speed   <= '0;
            motion_command <= '0;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            if (accept_bump) begin
                random_angle <= lfsr;
                if (bump_count != {CNT_W{1'b1}}) begin
                    bump_count <= bump_count + CNT_W'(1);
                end
            end
            if (turn_timeout) begin
                timeout_flag <= 1'b1;
            end
            output_speed   <= nxt_speed;
            motion_command <= nxt_cmd;
        end
    end

endmodule

// File: tb/tb_motion_arbiter.sv
// tb_motion_arbiter: table-driven directed vectors, hand-written corner
// sequences and randomized stimulus checked against a behavioural model.
module tb_motion_arbiter;

    localparam int         SETTLE_CYCLES = 4;
    localparam int         TURN_TIMEOUT  = 1023;
    localparam logic [9:0] LFSR_SEED     = 10'h2A5;
    localparam int         CNT_W         = 8;
    localparam int         MAX_BUMPS     = (1 << CNT_W) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_SPIRAL = 2;
    localparam int M_TURN   = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             bump;
    logic             done_spin;
    logic [2:0]       spiral_speed;
    logic [9:0]       spiral_cmd;
    logic [2:0]       turn_speed;
    logic [9:0]       turn_cmd;
    logic             spiral_enable;
    logic             turn_enable;
    logic [9:0]       random_angle;
    logic [2:0]       output_speed;
    logic [9:0]       motion_command;
    logic [1:0]       state;
    logic [CNT_W-1:0] bump_count;
    logic             timeout_flag;

    int checks;
    int errors;

    // Behavioural model: mode, pending mode and cycles spent in the current mode
    int         m_mode;
    int         m_next;
    int         m_age;
    int         m_bumps;
    logic [9:0] m_lfsr;
    logic [9:0] m_angle;
    logic       m_tflag;
    logic [2:0] m_speed;
    logic [9:0] m_cmd;

    typedef struct {
        logic       start;
        logic       stop;
        logic       bump;
        logic       done_spin;
        logic [1:0] exp_state;
        logic [2:0] exp_speed;
        logic [9:0] exp_cmd;
        logic [7:0] exp_bc;
    } vec_t;

    vec_t vecs[20];

    int         guard;
    int         turn_cycles;
    logic [7:0] saved_bc;
    logic [9:0] angle_one;

    motion_arbiter #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TURN_TIMEOUT  (TURN_TIMEOUT),
        .LFSR_SEED     (LFSR_SEED),
        .CNT_W         (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .bump           (bump),
        .done_spin      (done_spin),
        .spiral_speed   (spiral_speed),
        .spiral_cmd     (spiral_cmd),
        .turn_speed     (turn_speed),
        .turn_cmd       (turn_cmd),
        .spiral_enable  (spiral_enable),
        .turn_enable    (turn_enable),
        .random_angle   (random_angle),
        .output_speed   (output_speed),
        .motion_command (motion_command),
        .state          (state),
        .bump_count     (bump_count),
        .timeout_flag   (timeout_flag)
    );

    // Free-running 100 MHz-style clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_next  = M_SPIRAL;
        m_age   = 0;
        m_bumps = 0;
        m_lfsr  = LFSR_SEED;
        m_angle = 10'd0;
        m_tflag = 1'b0;
        m_speed = 3'd0;
        m_cmd   = 10'd0;
    endtask

    // One clock edge of the rules: stop wins, settle lasts SETTLE_CYCLES,
    // turn ends on done_spin or after TURN_TIMEOUT cycles
    task automatic model_edge();
        int mode_new;
        mode_new = m_mode;
        if (stop) begin
            mode_new = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (start) begin
                mode_new = M_SETTLE;
                m_next   = M_SPIRAL;
            end
        end else if (m_mode == M_SETTLE) begin
            if (m_age + 1 >= SETTLE_CYCLES) mode_new = m_next;
        end else if (m_mode == M_SPIRAL) begin
            if (bump) begin
                mode_new = M_SETTLE;
                m_next   = M_TURN;
                m_angle  = m_lfsr;
                if (m_bumps < MAX_BUMPS) m_bumps = m_bumps + 1;
            end
        end else begin
            if (done_spin) begin
                mode_new = M_SETTLE;
                m_next   = M_SPIRAL;
            end else if (m_age + 1 >= TURN_TIMEOUT) begin
                mode_new = M_SETTLE;
                m_next   = M_SPIRAL;
                m_tflag  = 1'b1;
            end
        end
        m_speed = 3'd0;
        m_cmd   = 10'd0;
        if (mode_new == m_mode && m_mode == M_SPIRAL) begin
            m_speed = spiral_speed;
            m_cmd   = spiral_cmd;
        end
        if (mode_new == m_mode && m_mode == M_TURN) begin
            m_speed = turn_speed;
            m_cmd   = turn_cmd;
        end
        m_age  = (mode_new == m_mode) ? m_age + 1 : 0;
        m_mode = mode_new;
        m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    endtask

    task automatic check_model();
        checkOutput("state", 32'(state), 32'(m_mode));
        checkOutput("spiral_enable", 32'(spiral_enable), 32'(m_mode == M_SPIRAL));
        checkOutput("turn_enable", 32'(turn_enable), 32'(m_mode == M_TURN));
        checkOutput("output_speed", 32'(output_speed), 32'(m_speed));
        checkOutput("motion_command", 32'(motion_command), 32'(m_cmd));
        checkOutput("random_angle", 32'(random_angle), 32'(m_angle));
        checkOutput("bump_count", 32'(bump_count), 32'(m_bumps));
        checkOutput("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
    endtask

    // Drive inputs, take one clock, advance the model and compare
    task automatic applyStimulus(input logic st, input logic sp, input logic bp, input logic ds);
        start     = st;
        stop      = sp;
        bump      = bp;
        done_spin = ds;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 32'd0);
        checkOutput({tag, "_enables"}, 32'({spiral_enable, turn_enable}), 32'd0);
        checkOutput({tag, "_bus"}, 32'({output_speed, motion_command}), 32'd0);
        checkOutput({tag, "_angle"}, 32'(random_angle), 32'd0);
        checkOutput({tag, "_bump_count"}, 32'(bump_count), 32'd0);
        checkOutput({tag, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        bump         = 1'b0;
        done_spin    = 1'b0;
        spiral_speed = 3'd5;
        spiral_cmd   = 10'h155;
        turn_speed   = 3'd3;
        turn_cmd     = 10'h0AA;
        model_reset();

        // Reset held for two cycles, released away from the edge
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero("reset_release");

        // Directed vectors: start, settle, spiral, bump, settle, turn, done_spin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 10'h000, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd5, 10'h155, 8'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 10'h000, 8'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd3, 10'h0AA, 8'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 3'd3, 10'h0AA, 8'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'h000, 8'd1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 10'h000, 8'd1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd5, 10'h155, 8'd1};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3'd0, 10'h000, 8'd2};

        angle_one = 10'd0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].bump, vecs[i].done_spin);
            checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            checkOutput($sformatf("vec%0d_bus", i), 32'({output_speed, motion_command}),
                        32'({vecs[i].exp_speed, vecs[i].exp_cmd}));
            checkOutput($sformatf("vec%0d_bump_count", i), 32'(bump_count), 32'(vecs[i].exp_bc));
            if (i == 6) begin
                angle_one = random_angle;
                checkOutput("first_angle_nonzero", 32'(random_angle != 10'd0), 32'd1);
            end
        end
        checkOutput("second_angle_differs", 32'(random_angle != angle_one), 32'd1);

        // Turn timeout: hold done_spin low until the turn is forced to end
        guard = 0;
        while (state != 2'd3 && guard < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        checkOutput("reach_turn", 32'(state), 32'd3);
        turn_cycles = 1;
        while (state == 2'd3 && turn_cycles < TURN_TIMEOUT + 50) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (state == 2'd3) turn_cycles++;
        end
        checkOutput("turn_timeout_cycles", 32'(turn_cycles), 32'(TURN_TIMEOUT));
        checkOutput("timeout_flag_set", 32'(timeout_flag), 32'd1);
        checkOutput("timeout_to_settle", 32'(state), 32'd1);
        repeat (SETTLE_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_back_to_spiral", 32'(state), 32'd2);

        // stop together with bump in SPIRAL: bump must not be counted
        saved_bc = bump_count;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("stop_state", 32'(state), 32'd0);
        checkOutput("stop_bump_count", 32'(bump_count), 32'(saved_bc));
        checkOutput("stop_bus", 32'({output_speed, motion_command}), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("stop_beats_start", 32'(state), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_rearm", 32'(state), 32'd1);
        checkOutput("flag_kept_through_idle", 32'(timeout_flag), 32'd1);

        // Randomized traffic checked against the model every cycle
        for (int n = 0; n < 4000; n++) begin
            spiral_speed = 3'($urandom_range(7, 0));
            spiral_cmd   = 10'($urandom_range(1023, 0));
            turn_speed   = 3'($urandom_range(7, 0));
            turn_cmd     = 10'($urandom_range(1023, 0));
            applyStimulus(1'($urandom_range(3, 0) == 0),
                          1'($urandom_range(63, 0) == 0),
                          1'($urandom_range(7, 0) == 0),
                          1'($urandom_range(11, 0) == 0));
        end

        // Mid-operation asynchronous reset clears everything without a clock
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_start", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
